weight_act_sequencer: RTL and testbench
=======================================

# weight_act_sequencer

- Sequences a ROWS×COLS grid of double-buffered PEs.
- Accepts weight tiles and activation vectors on two valid/ready streams.
- Drives the column-top weight bus (word format {data, sel, valid}) and the row-left activation bus, applying per-row skew.
- Manages the active/shadow bank swap, so the next tile's weights load while the current tile computes.

## Interface
Parameters:
- DATA_WIDTH, 8, weight/activation element width
- ROWS, 4, PE rows (activation lanes, weight beats per tile)
- COLS, 4, PE columns (weight lanes)

Ports (reset is asynchronous, active-low; one clock):
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- wt_valid_i  in  1  weight beat valid
- wt_ready_o  out  1  weight beat ready
- wt_data_i  in  COLS*DATA_WIDTH  one weight row, lane c = column c
- act_valid_i  in  1  activation vector valid
- act_ready_o  out  1  activation vector ready
- act_data_i  in  ROWS*DATA_WIDTH  lane r = row r
- act_last_i  in  1  final vector of current tile
- weight_o  out  COLS*(DATA_WIDTH+2)  per column {data[DATA_WIDTH+1:2], sel[1], valid[0]}
- act_o  out  ROWS*(DATA_WIDTH+2)  per row, data zero-extended
- bank_o  out  1  current active bank (sel value)
- tile_done_o  out  1  one-cycle pulse, tile fully drained
- busy_o  out  1  either FSM not idle

## Operation
Weight FSM (shadow bank):
- W_IDLE: wt_ready_o=1. First accepted beat → W_LOAD.
- W_LOAD: wt_ready_o=1. Counts accepted beats 0..ROWS-1, first beat = row ROWS-1. Last beat → W_SETTLE.
- W_SETTLE: wt_ready_o=0. Counts ROWS cycles for propagation, then → W_READY.
- W_READY: wt_ready_o=0. Shadow is full; waits for the swap.

Weight bus:
- Each accepted beat is registered onto weight_o: valid=1, sel=bank_o, data=lane.
- Otherwise weight_o carries valid=0, data=0, sel=bank_o.

Compute FSM:
- C_IDLE: act_ready_o=0.
- C_RUN: act_ready_o=1.
  - An accepted vector enters the skew pipe.
  - A non-accepted cycle inserts a zero vector.
  - Accepted act_last_i → C_DRAIN.
- C_DRAIN: act_ready_o=0. Zeros are inserted for ROWS+COLS cycles, then → C_IDLE with tile_done_o pulsed.

Swap:
- Occurs in any cycle with compute=C_IDLE and weight=W_READY.
- At the next edge: bank_o toggles, weight→W_IDLE, compute→C_RUN.
- Until the first swap after reset, compute stays C_IDLE and no activations are accepted.

Skew:
- Row r output is the registered input delayed by r further cycles (r extra stages).
- The new sel reaches row r through PE weight forwarding with matching delay.

busy_o = (weight≠W_IDLE) || (compute≠C_IDLE).

## Timing
- Reset (async assert, sync release): weight_o=0, act_o=0, bank_o=0, tile_done_o=0, busy_o=0, wt_ready_o=0 in reset and 1 after release, act_ready_o=0. Both FSMs idle, counters and skew registers cleared.
- Reset mid-operation:
  - A partial tile is discarded.
  - The in-flight skew is cleared.
  - bank_o returns to 0.
- Weight beat accepted at edge t → weight_o valid during cycle t+1 (1-cycle latency).
- Activation accepted at edge t → row r data on act_o during cycle t+1+r.
- Load time: ROWS beats plus ROWS settle cycles, then W_READY. Back-to-back beats give a minimum of 2·ROWS cycles.
- Drain and done:
  - tile_done_o is high in the first C_IDLE cycle after drain, i.e. ROWS+COLS+1 edges after act_last acceptance.
  - A swap can happen in that same cycle, so the earliest next activation acceptance is the cycle after tile_done_o.
- Boundary conditions:
  - Weight loading is independent of compute: the shadow may fill during C_RUN or C_DRAIN, then holds in W_READY until compute is idle.
  - wt_valid_i held in W_SETTLE or W_READY is not accepted; the source holds data (valid/ready rule: no drop, no duplicate).
  - act_last_i on a vector with act_valid_i=0 is ignored.
  - A single-vector tile (last on the first beat) is legal.
  - bank_o wraps 1→0 on alternate swaps.
- Streams obey standard valid/ready: the source keeps valid and data stable until accepted. Ready is a function of state only (no combinational path from valid).

## Test plan
- Reset, then 4 weight beats 0x01..0x04 back-to-back → weight_o valid on 4 consecutive cycles with sel=0 and lane data as sent. W_READY after 4 settle cycles, then swap: bank_o=1, act_ready_o=1.
- After swap, one vector {1,2,3,4} with last → act_o row r = r+1 at cycle t+1+r with other cycles 0. tile_done_o pulses at t+9 (ROWS+COLS+1).
- Second tile loaded during C_RUN of the first → holds W_READY with wt_ready_o=0, swaps in the tile_done_o cycle, bank_o returns 0, next vector accepted on the following cycle.
- act_valid_i toggled 1,0,1 within a tile → zero bubble appears on every row, correctly skewed between the two data vectors.
- Assert rst_ni low mid-W_LOAD (2 of 4 beats) and mid-C_RUN → all outputs 0 immediately. After release, a fresh 4-beat tile loads and swaps to bank_o=1.
- wt_valid_i held high with changing data while in W_SETTLE → no beat accepted and no weight_o valid until the next W_IDLE.

Source files
------------

// File: rtl/weight_act_sequencer.sv
// Feeds a ROWS x COLS double-buffered PE grid: loads weight tiles into the shadow bank,
// streams skewed activation vectors, and swaps banks when the shadow is full and compute is idle.
module weight_act_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              wt_valid_i,
    output logic                              wt_ready_o,
    input  logic [COLS*DATA_WIDTH-1:0]        wt_data_i,
    input  logic                              act_valid_i,
    output logic                              act_ready_o,
    input  logic [ROWS*DATA_WIDTH-1:0]        act_data_i,
    input  logic                              act_last_i,
    output logic [COLS*(DATA_WIDTH+2)-1:0]    weight_o,
    output logic [ROWS*(DATA_WIDTH+2)-1:0]    act_o,
    output logic                              bank_o,
    output logic                              tile_done_o,
    output logic                              busy_o
);

    localparam int EW = DATA_WIDTH + 2;
    localparam int CW = $clog2(ROWS + COLS + 1);

    typedef enum logic [1:0] {W_IDLE, W_LOAD, W_SETTLE, W_READY} w_state_t;
    typedef enum logic [1:0] {C_IDLE, C_RUN, C_DRAIN} c_state_t;

    w_state_t                  w_state_reg, w_state_next;
    logic [CW-1:0]             w_cnt_reg, w_cnt_next;
    c_state_t                  c_state_reg, c_state_next;
    logic [CW-1:0]             c_cnt_reg, c_cnt_next;
    logic                      bank_reg, bank_next;
    logic                      tile_done_reg, tile_done_next;
    logic                      wt_valid_reg;
    logic [COLS*DATA_WIDTH-1:0] wt_data_reg;
    logic [ROWS*DATA_WIDTH-1:0] act_in;
    logic                      wt_fire;
    logic                      act_fire;
    logic                      swap;

    // Ready is held low while reset is asserted so nothing is accepted before release.
    assign wt_ready_o  = rst_ni && ((w_state_reg == W_IDLE) || (w_state_reg == W_LOAD));
    assign act_ready_o = (c_state_reg == C_RUN);
    assign wt_fire     = wt_valid_i && wt_ready_o;
    assign act_fire    = act_valid_i && act_ready_o;
    assign swap        = (c_state_reg == C_IDLE) && (w_state_reg == W_READY);

    assign bank_o      = bank_reg;
    assign tile_done_o = tile_done_reg;
    assign busy_o      = (w_state_reg != W_IDLE) || (c_state_reg != C_IDLE);

    always_comb begin
        w_state_next = w_state_reg;
        w_cnt_next   = w_cnt_reg;
        unique case (w_state_reg)
            W_IDLE: begin
                if (wt_fire) begin
                    if (ROWS == 1) begin
                        w_state_next = W_SETTLE;
                        w_cnt_next   = '0;
                    end else begin
                        w_state_next = W_LOAD;
                        w_cnt_next   = CW'(1);
                    end
                end
            end
            W_LOAD: begin
                if (wt_fire) begin
                    if (w_cnt_reg == CW'(ROWS - 1)) begin
                        w_state_next = W_SETTLE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = w_cnt_reg + CW'(1);
                    end
                end
            end
            W_SETTLE: begin
                // Give the last beat ROWS cycles to ripple down to the bottom PE row.
                if (w_cnt_reg == CW'(ROWS - 1)) begin
                    w_state_next = W_READY;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = w_cnt_reg + CW'(1);
                end
            end
            W_READY: begin
                if (swap) begin
                    w_state_next = W_IDLE;
                end
            end
            default: begin
                w_state_next = W_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        c_state_next   = c_state_reg;
        c_cnt_next     = c_cnt_reg;
        tile_done_next = 1'b0;
        unique case (c_state_reg)
            C_IDLE: begin
                if (swap) begin
                    c_state_next = C_RUN;
                end
            end
            C_RUN: begin
                if (act_fire && act_last_i) begin
                    c_state_next = C_DRAIN;
                    c_cnt_next   = '0;
                end
            end
            C_DRAIN: begin
                // Flush the skew pipe and the PE array diagonal before reporting done.
                if (c_cnt_reg == CW'(ROWS + COLS - 1)) begin
                    c_state_next   = C_IDLE;
                    c_cnt_next     = '0;
                    tile_done_next = 1'b1;
                end else begin
                    c_cnt_next = c_cnt_reg + CW'(1);
                end
            end
            default: begin
                c_state_next = C_IDLE;
                c_cnt_next   = '0;
            end
        endcase
    end

    assign bank_next = swap ? ~bank_reg : bank_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_reg   <= W_IDLE;
            w_cnt_reg     <= '0;
            c_state_reg   <= C_IDLE;
            c_cnt_reg     <= '0;
            bank_reg      <= 1'b0;
            tile_done_reg <= 1'b0;
        end else begin
            w_state_reg   <= w_state_next;
            w_cnt_reg     <= w_cnt_next;
            c_state_reg   <= c_state_next;
            c_cnt_reg     <= c_cnt_next;
            bank_reg      <= bank_next;
            tile_done_reg <= tile_done_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wt_valid_reg <= 1'b0;
            wt_data_reg  <= '0;
        end else begin
            wt_valid_reg <= wt_fire;
            wt_data_reg  <= wt_fire ? wt_data_i : '0;
        end
    end

    // sel always mirrors the live bank so PEs forward the new select right after a swap.
    for (genvar gi = 0; gi < COLS; gi++) begin : g_wcol
        assign weight_o[gi*EW +: EW] = {wt_data_reg[gi*DATA_WIDTH +: DATA_WIDTH], bank_reg, wt_valid_reg};
    end

    assign act_in = act_fire ? act_data_i : '0;

    // Row gi sees its lane through gi+1 register stages, giving the diagonal wavefront.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_skew
        logic [DATA_WIDTH-1:0] skew_reg [gi+1];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int k = 0; k <= gi; k++) begin
                    skew_reg[k] <= '0;
                end
            end else begin
                skew_reg[0] <= act_in[gi*DATA_WIDTH +: DATA_WIDTH];
                for (int k = 1; k <= gi; k++) begin
                    skew_reg[k] <= skew_reg[k-1];
                end
            end
        end

        assign act_o[gi*EW +: EW] = {2'b00, skew_reg[gi]};
    end

endmodule

// File: tb/tb_weight_act_sequencer.sv
// Randomised bench for weight_act_sequencer; a timestamp-based model predicts every output each cycle.
module tb_weight_act_sequencer;

    localparam int DW  = 8;
    localparam int R   = 4;
    localparam int C   = 4;
    localparam int EW  = DW + 2;
    localparam int SCH = 64;

    typedef struct packed {
        logic          v;
        logic [C*DW-1:0] d;
    } wt_beat_t;

    typedef struct packed {
        logic          v;
        logic          last;
        logic [R*DW-1:0] d;
    } act_vec_t;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              wt_valid_i = 1'b0;
    logic              wt_ready_o;
    logic [C*DW-1:0]   wt_data_i = '0;
    logic              act_valid_i = 1'b0;
    logic              act_ready_o;
    logic [R*DW-1:0]   act_data_i = '0;
    logic              act_last_i = 1'b0;
    logic [C*EW-1:0]   weight_o;
    logic [R*EW-1:0]   act_o;
    logic              bank_o;
    logic              tile_done_o;
    logic              busy_o;

    weight_act_sequencer #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wt_valid_i (wt_valid_i),
        .wt_ready_o (wt_ready_o),
        .wt_data_i  (wt_data_i),
        .act_valid_i(act_valid_i),
        .act_ready_o(act_ready_o),
        .act_data_i (act_data_i),
        .act_last_i (act_last_i),
        .weight_o   (weight_o),
        .act_o      (act_o),
        .bank_o     (bank_o),
        .tile_done_o(tile_done_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Model: edge counter and timestamps of tile events.
    int  n = 0;
    int  m_beats = 0;
    int  m_full_edge = 0;
    bit  m_run = 0;
    bit  m_drain = 0;
    int  m_last_edge = 0;
    int  m_swaps = 0;
    bit  exp_wv = 0;
    logic [C*DW-1:0] exp_wd = '0;
    logic [DW-1:0] sched [SCH][R];

    int  first_wt_edge = 0;
    int  last_act_edge = 0;
    int  done_edge = 0;

    wt_beat_t wt_q[$];
    act_vec_t act_q[$];
    bit wt_pending = 0, act_pending = 0;
    bit wt_acc_prev = 0, act_acc_prev = 0;
    bit wiggle = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    function automatic bit m_wt_ready();
        return m_beats < R;
    endfunction

    function automatic bit m_act_ready();
        return m_run && !m_drain;
    endfunction

    function automatic bit m_shadow_ready();
        return (m_beats == R) && (n >= m_full_edge + R);
    endfunction

    function automatic bit m_compute_idle();
        return !m_run || (m_drain && (n >= m_last_edge + R + C));
    endfunction

    function automatic logic [C*DW-1:0] rand_wt();
        logic [C*DW-1:0] v;
        for (int c = 0; c < C; c++) v[c*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    function automatic logic [R*DW-1:0] rand_act();
        logic [R*DW-1:0] v;
        for (int r = 0; r < R; r++) v[r*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic model_clear();
        m_beats = 0; m_run = 0; m_drain = 0; m_swaps = 0;
        exp_wv = 0; exp_wd = '0;
        for (int s = 0; s < SCH; s++)
            for (int r = 0; r < R; r++) sched[s][r] = '0;
    endtask

    task automatic check_outputs();
        logic [C*EW-1:0] ew;
        logic [R*EW-1:0] ea;
        logic            bank_e;
        bank_e = m_swaps[0];
        for (int c = 0; c < C; c++)
            ew[c*EW +: EW] = {(exp_wv ? exp_wd[c*DW +: DW] : DW'(0)), bank_e, exp_wv};
        for (int r = 0; r < R; r++)
            ea[r*EW +: EW] = {2'b00, sched[n % SCH][r]};
        check_eq("weight_o", 64'(weight_o), 64'(ew));
        check_eq("act_o", 64'(act_o), 64'(ea));
        check_eq("bank_o", 64'(bank_o), 64'(bank_e));
        check_eq("tile_done_o", 64'(tile_done_o),
                 64'(m_run && m_drain && (n == m_last_edge + R + C)));
        check_eq("busy_o", 64'(busy_o), 64'((m_beats > 0) || !m_compute_idle()));
        check_eq("wt_ready_o", 64'(wt_ready_o), 64'(m_wt_ready()));
        check_eq("act_ready_o", 64'(act_ready_o), 64'(m_act_ready()));
    endtask

    task automatic drive_sources();
        wt_beat_t wb;
        act_vec_t av;
        if (!(wt_pending && !wt_acc_prev)) begin
            wt_pending = 0;
            if (wt_q.size() > 0) begin
                wb = wt_q.pop_front();
                wt_valid_i = wb.v;
                wt_data_i  = wb.d;
                wt_pending = wb.v;
            end else if (wiggle && !m_wt_ready()) begin
                wt_valid_i = 1'b1;
                wt_data_i  = rand_wt();
            end else begin
                wt_valid_i = 1'b0;
            end
        end
        if (!(act_pending && !act_acc_prev)) begin
            act_pending = 0;
            if (act_q.size() > 0) begin
                av = act_q.pop_front();
                act_valid_i = av.v;
                act_data_i  = av.d;
                act_last_i  = av.last;
                act_pending = av.v;
            end else begin
                act_valid_i = 1'b0;
                act_last_i  = 1'($urandom);
            end
        end
    endtask

    task automatic tick();
        bit wa, aa, sw, al;
        logic [C*DW-1:0] wd;
        logic [R*DW-1:0] ad;
        drive_sources();
        wa = wt_valid_i && m_wt_ready();
        aa = act_valid_i && m_act_ready();
        sw = m_shadow_ready() && m_compute_idle();
        wd = wt_data_i;
        ad = act_data_i;
        al = act_last_i;
        @(posedge clk_i);
        n++;
        exp_wv = wa;
        exp_wd = wd;
        if (wa) begin
            if (m_beats == 0) first_wt_edge = n;
            m_beats++;
            if (m_beats == R) m_full_edge = n;
        end
        for (int r = 0; r < R; r++)
            sched[(n + r) % SCH][r] = aa ? ad[r*DW +: DW] : DW'(0);
        if (aa && al) begin
            m_drain = 1;
            m_last_edge = n;
            last_act_edge = n;
        end
        if (sw) begin
            m_swaps++;
            m_beats = 0;
            m_run = 1;
            m_drain = 0;
        end
        wt_acc_prev  = wa;
        act_acc_prev = aa;
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        check_eq("rst_weight_o", 64'(weight_o), 64'd0);
        check_eq("rst_act_o", 64'(act_o), 64'd0);
        check_eq("rst_bank_o", 64'(bank_o), 64'd0);
        check_eq("rst_tile_done", 64'(tile_done_o), 64'd0);
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        check_eq("rst_wt_ready", 64'(wt_ready_o), 64'd0);
        check_eq("rst_act_ready", 64'(act_ready_o), 64'd0);
        model_clear();
        wt_q.delete();
        act_q.delete();
        wt_pending = 0; act_pending = 0;
        wt_acc_prev = 0; act_acc_prev = 0;
        wt_valid_i = 0; act_valid_i = 0; act_last_i = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check_eq("rel_wt_ready", 64'(wt_ready_o), 64'd1);
    endtask

    task automatic push_wt_tile(input int base);
        wt_beat_t b;
        for (int k = 0; k < R; k++) begin
            b.v = 1'b1;
            for (int c = 0; c < C; c++) b.d[c*DW +: DW] = DW'(base + k + 16 * c);
            wt_q.push_back(b);
        end
    endtask

    task automatic push_act(input bit v, input bit last, input logic [R*DW-1:0] d);
        act_vec_t a;
        a.v = v; a.last = last; a.d = d;
        act_q.push_back(a);
    endtask

    task automatic wait_bank(input bit b, input string tag);
        int k = 0;
        while (bank_o !== b && k < 100) begin tick(); k++; end
        check_eq(tag, 64'(bank_o), 64'(b));
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (tile_done_o !== 1'b1 && k < 100) begin tick(); k++; end
        check_eq({tag, "_seen"}, 64'(tile_done_o), 64'd1);
        check_eq({tag, "_latency"}, 64'(n - last_act_edge), 64'(R + C + 1 - 1));
        done_edge = n;
    endtask

    initial begin
        logic [R*DW-1:0] v;
        int k;
        @(negedge clk_i);
        do_reset();

        // First tile: 4 back-to-back beats then swap to bank 1.
        push_wt_tile(1);
        wait_bank(1'b1, "swap1_bank");
        check_eq("swap1_latency", 64'(n - first_wt_edge), 64'(2 * R));
        check_eq("swap1_act_ready", 64'(act_ready_o), 64'd1);

        // Single-vector tile {1,2,3,4} while the next tile loads into the shadow.
        for (int r = 0; r < R; r++) v[r*DW +: DW] = DW'(r + 1);
        push_act(1'b1, 1'b1, v);
        push_wt_tile(8'h21);
        wait_done("done1");

        // Next tile with a bubble; first vector must land the cycle after tile_done.
        for (int r = 0; r < R; r++) v[r*DW +: DW] = DW'(8'h81 + r);
        push_act(1'b1, 1'b0, v);
        push_act(1'b0, 1'b1, rand_act());
        push_act(1'b1, 1'b1, rand_act());
        k = 0;
        while (act_o[EW-1:0] !== {2'b00, 8'h81} && k < 50) begin tick(); k++; end
        check_eq("accept_gap", 64'(n - done_edge), 64'd2);
        check_eq("swap2_bank", 64'(bank_o), 64'd0);

        // Third tile loads with a misbehaving source wiggling data while not ready.
        wiggle = 1;
        push_wt_tile(8'h41);
        wait_done("done2");
        wait_bank(1'b1, "swap3_bank");
        wiggle = 0;

        // Reset in the middle of a weight load.
        wt_q.delete();
        for (int j = 0; j < 2; j++) push_wt_tile(8'h61);
        void'(wt_q.pop_back()); void'(wt_q.pop_back());
        void'(wt_q.pop_back()); void'(wt_q.pop_back());
        wt_q = wt_q[0:1];
        k = 0;
        while (m_beats < 2 && k < 20) begin tick(); k++; end
        do_reset();
        push_wt_tile(8'h71);
        wait_bank(1'b1, "swap4_bank");
        check_eq("swap4_latency", 64'(n - first_wt_edge), 64'(2 * R));

        // Reset while activations are in flight.
        push_act(1'b1, 1'b0, rand_act());
        push_act(1'b1, 1'b0, rand_act());
        k = 0;
        while (!act_acc_prev && k < 20) begin tick(); k++; end
        tick();
        do_reset();
        push_wt_tile(8'h91);
        wait_bank(1'b1, "swap5_bank");

        // Random traffic on both streams.
        for (int i = 0; i < 1500; i++) begin
            wt_beat_t wb;
            act_vec_t av;
            wiggle = ($urandom_range(0, 2) == 0);
            if (wt_q.size() < 2) begin
                wb.v = ($urandom_range(0, 3) != 0);
                wb.d = rand_wt();
                wt_q.push_back(wb);
            end
            if (act_q.size() < 2) begin
                av.v = ($urandom_range(0, 2) != 0);
                av.last = ($urandom_range(0, 4) == 0);
                av.d = rand_act();
                act_q.push_back(av);
            end
            if ($urandom_range(0, 699) == 0) do_reset();
            else tick();
        end
        wiggle = 0;
        wt_q.delete();
        act_q.delete();
        repeat (40) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
